prg_dma_loader: RTL and testbench

PRG_DMA_LOADER -- requirements
Module: prg_dma_loader

---
 rtl/prg_dma_loader_if.sv | 25 ++
 rtl/prg_dma_loader.sv | 98 +++++++++
 tb/tb_prg_dma_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/prg_dma_loader_if.sv
// prg_dma_loader_if: control, c64 bus and ROM signals of the PRG DMA loader
interface prg_dma_loader_if #(parameter int ROM_AW = 13) ();
  logic              start;
  logic [15:0]       len;
  logic [15:0]       load_addr;
  logic              phi2;
  logic              ba;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              dma;
  logic [15:0]       ao;
  logic [7:0]        d_o;
  logic              rw;
  logic              busy;
  logic              done;
  logic              overflow;
  modport master (
    output start, len, load_addr, phi2, ba, rom_data,
    input  rom_addr, dma, ao, d_o, rw, busy, done, overflow
  );
  modport slave (
    input  start, len, load_addr, phi2, ba, rom_data,
    output rom_addr, dma, ao, d_o, rw, busy, done, overflow
  );
endinterface

// File: rtl/prg_dma_loader.sv
// prg_dma_loader: copies a ROM image into c64 memory over DMA, one byte per phi2 cycle.
// Define PRG_HEADER_EN to take the target address from the 2-byte PRG header instead of load_addr.
module prg_dma_loader #(parameter int ROM_AW = 13) (
  input logic            clk,
  input logic            reset,
  prg_dma_loader_if.slave bus
);
`ifdef PRG_HEADER_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_WR, FINISH, HDR_LO, HDR_HI} state_t;
  logic unused_load_addr;
  assign unused_load_addr = ^bus.load_addr;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_WR, FINISH} state_t;
`endif
  state_t            state_q;
  logic [ROM_AW-1:0] rom_addr_q, rom_inc;
  logic [15:0]       ao_q, cnt_q;
  logic [7:0]        d_o_q;
  logic              dma_q, rw_q, busy_q, done_q, ovf_q, phi2_q, ba_ok_q;
  logic              commit, last;
  // ba_ok_q: ba has been 1 on every clk of the current/last phi2-high phase
  assign commit  = phi2_q & ~bus.phi2 & ba_ok_q;
  assign last    = cnt_q == 16'd1 || ao_q == 16'hFFFF;
  assign rom_inc = rom_addr_q + ROM_AW'(~&rom_addr_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      rom_addr_q <= '0;
      ao_q       <= '0;
      cnt_q      <= '0;
      d_o_q      <= '0;
      dma_q      <= 1'b0;
      rw_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      phi2_q     <= 1'b0;
      ba_ok_q    <= 1'b0;
    end else begin
      phi2_q  <= bus.phi2;
      ba_ok_q <= bus.phi2 & bus.ba & (~phi2_q | ba_ok_q);
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          cnt_q      <= bus.len;
          rom_addr_q <= '0;
          ovf_q      <= 1'b0;
`ifdef PRG_HEADER_EN
          busy_q     <= 1'b1;
          state_q    <= HDR_LO;
        end
        HDR_LO: begin
          ao_q[7:0]  <= bus.rom_data;
          rom_addr_q <= rom_inc;
          state_q    <= HDR_HI;
        end
        HDR_HI: begin
          ao_q[15:8] <= bus.rom_data;
          rom_addr_q <= rom_inc;
`else
          ao_q       <= bus.load_addr;
`endif
          state_q    <= bus.len == 16'd0 ? FINISH : FETCH;
          busy_q     <= bus.len != 16'd0;
          dma_q      <= bus.len != 16'd0;
          done_q     <= bus.len == 16'd0;
        end
        FETCH: begin
          d_o_q   <= bus.rom_data;
          rw_q    <= 1'b0;
          state_q <= WAIT_WR;
        end
        WAIT_WR: if (commit) begin
          rw_q       <= 1'b1;
          ao_q       <= ao_q + 16'(ao_q != 16'hFFFF);
          rom_addr_q <= rom_inc;
          cnt_q      <= cnt_q - 16'd1;
          ovf_q      <= ao_q == 16'hFFFF && cnt_q != 16'd1;
          state_q    <= last ? FINISH : FETCH;
          dma_q      <= ~last;
          busy_q     <= ~last;
          done_q     <= last;
        end
        default: state_q <= IDLE;
      endcase
    end
`ifdef PRG_HEADER_EN
`else
`endif
  assign bus.rom_addr = rom_addr_q;
  assign bus.dma      = dma_q;
  assign bus.ao       = ao_q;
  assign bus.d_o      = d_o_q;
  assign bus.rw       = rw_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_prg_dma_loader.sv
// tb_prg_dma_loader: directed loads with a write scoreboard checked by a c64 bus monitor
`timescale 1ns/1ps
module tb_prg_dma_loader;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  prg_dma_loader_if #(.ROM_AW(3)) bus();
  prg_dma_loader #(.ROM_AW(3)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  logic [7:0] rom [8];
  assign bus.rom_data = rom[bus.rom_addr];
  logic [2:0] ph = 3'd0;
  always @(posedge clk) begin
    #1;
    ph = ph + 3'd1;
    bus.phi2 = ph[2];
  end
  int passed = 0, total = 0, ncommit = 0, ndone = 0;
  bit dma_seen = 1'b0;
  logic pphi = 1'b0, bok = 1'b0;
  logic [23:0] exp_q [$];
  logic [7:0] pay [$], expd [$];
`ifdef PRG_HEADER_EN
  localparam int HDR_LAT = 2;
`else
  localparam int HDR_LAT = 0;
`endif
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endfunction
  // c64 side: a write lands on a phi2 fall if ba stayed high through the high phase
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.dma) dma_seen = 1'b1;
      if (bus.done) ndone++;
      if (bus.dma && !bus.rw && pphi && !bus.phi2 && bok) begin
        ncommit++;
        if (exp_q.size() == 0) chk("write_unexpected", exp_q.size(), 1);
        else chk("write", {bus.ao, bus.d_o}, exp_q.pop_front());
      end
    end
    bok  = bus.phi2 & bus.ba & (!pphi | bok);
    pphi = bus.phi2;
  end
  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic wait_commits(int n);
    int k = 0;
    while (ncommit < n && k < 400) begin
      cyc();
      k++;
    end
    chk("commit_wait", ncommit, n);
  endtask
  task automatic wait_phi(logic v);
    int k = 0;
    while (bus.phi2 !== v && k < 20) begin
      cyc();
      k++;
    end
  endtask
  task automatic run(string nm, logic [15:0] tgt, logic [15:0] len, logic ovf, int mode);
    int d0, c0, lat;
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
`ifdef PRG_HEADER_EN
    rom[0] = tgt[7:0];
    rom[1] = tgt[15:8];
    for (int i = 0; i < 6 && i < pay.size(); i++) rom[i+2] = pay[i];
    bus.load_addr = 16'h1234;
`else
    for (int i = 0; i < 8 && i < pay.size(); i++) rom[i] = pay[i];
    bus.load_addr = tgt;
`endif
    foreach (expd[i]) exp_q.push_back({tgt + 16'(i), expd[i]});
    d0 = ndone;
    c0 = ncommit;
    dma_seen = 1'b0;
    bus.len = len;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    if (mode == 1) begin
      wait_commits(c0 + 1);
      bus.len = 16'd1;
      bus.load_addr = 16'h9999;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
    end else if (mode == 2) begin
      wait_commits(c0 + 1);
      wait_phi(1'b1);
      bus.ba = 1'b0;
      wait_phi(1'b0);
      bus.ba = 1'b1;
    end else if (mode == 3) begin
      wait_commits(c0 + 2);
      #4 reset = 1'b1;
      #1 chk({nm, "_async"}, {bus.dma, bus.rw, bus.busy}, 3'b010);
      #1 reset = 1'b0;
      exp_q.delete();
      cyc(30);
      chk({nm, "_no_done"}, ndone - d0, 0);
      chk({nm, "_no_more_writes"}, ncommit - c0, 2);
      return;
    end
    lat = 0;
    while (!bus.done && lat < 400) begin
      cyc();
      lat++;
    end
    if (len == 16'd0) begin
      chk({nm, "_done_latency"}, lat, HDR_LAT);
      chk({nm, "_dma_never"}, dma_seen, 0);
    end
    chk({nm, "_overflow"}, bus.overflow, ovf);
    chk({nm, "_busy_at_done"}, bus.busy, 0);
    cyc(3);
    chk({nm, "_done_count"}, ndone - d0, 1);
    chk({nm, "_pending_writes"}, exp_q.size(), 0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.len = 16'd0;
    bus.load_addr = 16'd0;
    bus.ba = 1'b1;
    bus.phi2 = 1'b0;
    for (int i = 0; i < 8; i++) rom[i] = 8'h00;
    #12;
    chk("reset_ctrl", {bus.dma, bus.rw, bus.busy, bus.done, bus.overflow}, 5'b01000);
    chk("reset_regs", {bus.ao, bus.d_o, bus.rom_addr}, 0);
    reset = 1'b0;
    cyc(2);
    pay = '{8'hA9, 8'h00, 8'h60};
    expd = pay;
    run("basic", 16'h0801, 16'd3, 1'b0, 0);
    run("ba_stall", 16'h0801, 16'd3, 1'b0, 2);
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    expd = '{8'hAA, 8'hBB};
    run("wrap", 16'hFFFE, 16'd4, 1'b1, 0);
    pay.delete();
    expd.delete();
    run("len0", 16'hC000, 16'd0, 1'b0, 0);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    expd = pay;
    run("reset_abort", 16'h2000, 16'd4, 1'b0, 3);
    pay = '{8'h5A, 8'hA5, 8'h3C};
    expd = pay;
    run("after_reset", 16'h3000, 16'd3, 1'b0, 0);
    pay = '{8'h01, 8'h02, 8'h03};
    expd = pay;
    run("start_busy", 16'h4000, 16'd3, 1'b0, 1);
    pay = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
`ifdef PRG_HEADER_EN
    expd = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h60, 8'h60, 8'h60, 8'h60};
`else
    expd = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h80, 8'h80};
`endif
    run("rom_sat", 16'h5000, 16'd10, 1'b0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
